// File: rtl/rcc_ahb_lite_master.sv
// rcc_ahb_lite_master: single-outstanding AHB-Lite master bridging a simple
// req/rsp requester port onto the bus. One transfer at a time, SINGLE bursts,
// NONSEQ/IDLE only; byte enables select transfer size and address offset.
module rcc_ahb_lite_master #(
  parameter logic [2:0] ADDR_HI = 3'b000
) (
  input  logic        ahb_hclk,
  input  logic        ahb_hreset,
  input  logic        req,
  input  logic [3:0]  we,
  input  logic [28:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [1:0]  rsp,
  output logic [31:0] ahb_haddr,
  output logic [1:0]  ahb_htrans,
  output logic        ahb_hwrite,
  output logic [2:0]  ahb_hsize,
  output logic [2:0]  ahb_hburst,
  output logic [2:0]  ahb_hprot,
  output logic [31:0] ahb_hwdata,
  input  logic [31:0] ahb_hrdata,
  input  logic        ahb_hready,
  input  logic        ahb_hresp
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  localparam logic [1:0] RSP_NONE  = 2'b00;
  localparam logic [1:0] RSP_OKAY  = 2'b01;
  localparam logic [1:0] RSP_ERROR = 2'b11;

  state_t      state;
  state_t      state_next;
  logic        we_legal;
  logic [2:0]  we_size;
  logic [1:0]  we_off;
  logic [1:0]  rsp_code;
  logic [31:0] haddr_q;
  logic        hwrite_q;
  logic [2:0]  hsize_q;
  logic [31:0] hwdata_q;
  logic [31:0] rdata_q;
  logic        addr_low_unused;

  // The requester's low address bits carry no meaning; the byte enables set the offset.
  assign addr_low_unused = ^addr[1:0];

  // Decode the byte-enable pattern into legality, transfer size and byte offset.
  always_comb begin
    we_legal = 1'b1;
    we_size  = 3'b010;
    we_off   = 2'b00;
    case (we)
      4'b0000: begin we_size = 3'b010; we_off = 2'b00; end
      4'b1111: begin we_size = 3'b010; we_off = 2'b00; end
      4'b0011: begin we_size = 3'b001; we_off = 2'b00; end
      4'b1100: begin we_size = 3'b001; we_off = 2'b10; end
      4'b0001: begin we_size = 3'b000; we_off = 2'b00; end
      4'b0010: begin we_size = 3'b000; we_off = 2'b01; end
      4'b0100: begin we_size = 3'b000; we_off = 2'b10; end
      4'b1000: begin we_size = 3'b000; we_off = 2'b11; end
      default: we_legal = 1'b0;
    endcase
  end

  // State register; reset abandons any transfer in flight without a response.
  always_ff @(posedge ahb_hclk) begin
    if (ahb_hreset) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state logic: illegal enables skip the bus and report an error directly.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req) state_next = we_legal ? ADDR : RESP;
      ADDR: if (ahb_hready) state_next = DATA;
      DATA: if (ahb_hready) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transfer registers: latch the request in IDLE, capture the result at the end of DATA.
  always_ff @(posedge ahb_hclk) begin
    if (ahb_hreset) begin
      haddr_q  <= 32'h0;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'b010;
      hwdata_q <= 32'h0;
      rdata_q  <= 32'h0;
      rsp_code <= RSP_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (we_legal) begin
              haddr_q  <= {ADDR_HI, addr[28:2], we_off};
              hwrite_q <= (we != 4'b0000);
              hsize_q  <= we_size;
              hwdata_q <= wdata;
            end else begin
              rsp_code <= RSP_ERROR;
            end
          end
        end
        DATA: begin
          if (ahb_hready) begin
            if (ahb_hresp) begin
              rsp_code <= RSP_ERROR;
            end else begin
              rsp_code <= RSP_OKAY;
              if (!hwrite_q) rdata_q <= ahb_hrdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ahb_htrans = (state == ADDR) ? 2'b10 : 2'b00;
  assign rsp        = (state == RESP) ? rsp_code : RSP_NONE;
  assign rdata      = rdata_q;
  assign ahb_haddr  = haddr_q;
  assign ahb_hwrite = hwrite_q;
  assign ahb_hsize  = hsize_q;
  assign ahb_hwdata = hwdata_q;
  assign ahb_hburst = 3'b000;
  assign ahb_hprot  = 3'b011;

endmodule

// File: tb/tb_rcc_ahb_lite_master.sv
// tb_rcc_ahb_lite_master: directed scenarios for the AHB-Lite master with
// hand-computed expectations; inputs driven and outputs sampled on the falling edge.
module tb_rcc_ahb_lite_master;

  logic        clk;
  logic        rst;
  logic        req;
  logic [3:0]  we;
  logic [28:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  rsp;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [2:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int checks = 0;
  int errors = 0;

  rcc_ahb_lite_master #(.ADDR_HI(3'b000)) dut (
    .ahb_hclk   (clk),
    .ahb_hreset (rst),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .rsp        (rsp),
    .ahb_haddr  (haddr),
    .ahb_htrans (htrans),
    .ahb_hwrite (hwrite),
    .ahb_hsize  (hsize),
    .ahb_hburst (hburst),
    .ahb_hprot  (hprot),
    .ahb_hwdata (hwdata),
    .ahb_hrdata (hrdata),
    .ahb_hready (hready),
    .ahb_hresp  (hresp)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 4'b0000; addr = 29'h0; wdata = 32'h0;
    hrdata = 32'h0; hready = 1'b1; hresp = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (htrans !== 2'b00) begin errors++; $display("[TB] FAIL rst_htrans got %b exp %b", htrans, 2'b00); end
    checks++; if (rsp !== 2'b00) begin errors++; $display("[TB] FAIL rst_rsp got %b exp %b", rsp, 2'b00); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata got %h exp %h", rdata, 32'h0); end
    checks++; if (haddr !== 32'h0) begin errors++; $display("[TB] FAIL rst_haddr got %h exp %h", haddr, 32'h0); end
    checks++; if (hwrite !== 1'b0) begin errors++; $display("[TB] FAIL rst_hwrite got %b exp %b", hwrite, 1'b0); end
    checks++; if (hsize !== 3'b010) begin errors++; $display("[TB] FAIL rst_hsize got %b exp %b", hsize, 3'b010); end
    checks++; if (hwdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_hwdata got %h exp %h", hwdata, 32'h0); end
    checks++; if (hburst !== 3'b000) begin errors++; $display("[TB] FAIL rst_hburst got %b exp %b", hburst, 3'b000); end
    checks++; if (hprot !== 3'b011) begin errors++; $display("[TB] FAIL rst_hprot got %b exp %b", hprot, 3'b011); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (htrans !== 2'b00) begin errors++; $display("[TB] FAIL idle_htrans got %b exp %b", htrans, 2'b00); end
  endtask

  task automatic test_word_write();
    // cycle N: request sampled at the end of this cycle
    req = 1'b1; we = 4'b1111; addr = 29'h0000_0104; wdata = 32'hDEADBEEF;
    @(negedge clk); // N+1: address phase
    checks++; if (htrans !== 2'b10) begin errors++; $display("[TB] FAIL ww_htrans got %b exp %b", htrans, 2'b10); end
    checks++; if (haddr !== 32'h0000_0104) begin errors++; $display("[TB] FAIL ww_haddr got %h exp %h", haddr, 32'h0000_0104); end
    checks++; if (hsize !== 3'b010) begin errors++; $display("[TB] FAIL ww_hsize got %b exp %b", hsize, 3'b010); end
    checks++; if (hwrite !== 1'b1) begin errors++; $display("[TB] FAIL ww_hwrite got %b exp %b", hwrite, 1'b1); end
    addr = 29'h1FFF_FFF0; wdata = 32'h0; we = 4'b0001;
    @(negedge clk); // N+2: data phase
    checks++; if (htrans !== 2'b00) begin errors++; $display("[TB] FAIL ww_data_htrans got %b exp %b", htrans, 2'b00); end
    checks++; if (hwdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL ww_hwdata got %h exp %h", hwdata, 32'hDEADBEEF); end
    checks++; if (haddr !== 32'h0000_0104) begin errors++; $display("[TB] FAIL ww_haddr_hold got %h exp %h", haddr, 32'h0000_0104); end
    checks++; if (rsp !== 2'b00) begin errors++; $display("[TB] FAIL ww_rsp_early got %b exp %b", rsp, 2'b00); end
    @(negedge clk); // N+3: response
    checks++; if (rsp !== 2'b01) begin errors++; $display("[TB] FAIL ww_rsp got %b exp %b", rsp, 2'b01); end
    req = 1'b0;
    @(negedge clk);
    checks++; if (rsp !== 2'b00) begin errors++; $display("[TB] FAIL ww_rsp_one got %b exp %b", rsp, 2'b00); end
    checks++; if (htrans !== 2'b00) begin errors++; $display("[TB] FAIL ww_after_htrans got %b exp %b", htrans, 2'b00); end
  endtask

  task automatic test_read_wait();
    req = 1'b1; we = 4'b0000; addr = 29'h0000_0200; wdata = 32'h0;
    @(negedge clk); // N+1
    checks++; if (htrans !== 2'b10) begin errors++; $display("[TB] FAIL rd_htrans got %b exp %b", htrans, 2'b10); end
    checks++; if (hwrite !== 1'b0) begin errors++; $display("[TB] FAIL rd_hwrite got %b exp %b", hwrite, 1'b0); end
    checks++; if (haddr !== 32'h0000_0200) begin errors++; $display("[TB] FAIL rd_haddr got %h exp %h", haddr, 32'h0000_0200); end
    @(negedge clk); // N+2..N+4: three wait states
    hready = 1'b0; hrdata = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp !== 2'b00) begin errors++; $display("[TB] FAIL rd_wait_rsp%0d got %b exp %b", i, rsp, 2'b00); end
      checks++; if (haddr !== 32'h0000_0200) begin errors++; $display("[TB] FAIL rd_wait_haddr%0d got %h exp %h", i, haddr, 32'h0000_0200); end
      @(negedge clk);
    end
    hready = 1'b1; hrdata = 32'h1234_5678; // N+5: completes
    checks++; if (rsp !== 2'b00) begin errors++; $display("[TB] FAIL rd_last_rsp got %b exp %b", rsp, 2'b00); end
    @(negedge clk); // N+6
    checks++; if (rsp !== 2'b01) begin errors++; $display("[TB] FAIL rd_rsp got %b exp %b", rsp, 2'b01); end
    checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL rd_rdata got %h exp %h", rdata, 32'h1234_5678); end
    req = 1'b0; hrdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL rd_rdata_hold got %h exp %h", rdata, 32'h1234_5678); end
  endtask

  task automatic test_error_read();
    req = 1'b1; we = 4'b0000; addr = 29'h0000_0300;
    @(negedge clk); // N+1 address phase
    checks++; if (htrans !== 2'b10) begin errors++; $display("[TB] FAIL er_htrans got %b exp %b", htrans, 2'b10); end
    @(negedge clk); // N+2 first ERROR cycle
    hready = 1'b0; hresp = 1'b1; hrdata = 32'hFFFF_0000;
    @(negedge clk); // N+3 second ERROR cycle
    checks++; if (rsp !== 2'b00) begin errors++; $display("[TB] FAIL er_rsp_early got %b exp %b", rsp, 2'b00); end
    hready = 1'b1; hresp = 1'b1;
    @(negedge clk); // N+4 response
    hresp = 1'b0;
    checks++; if (rsp !== 2'b11) begin errors++; $display("[TB] FAIL er_rsp got %b exp %b", rsp, 2'b11); end
    checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL er_rdata got %h exp %h", rdata, 32'h1234_5678); end
    req = 1'b0;
    @(negedge clk);
    checks++; if (rsp !== 2'b00) begin errors++; $display("[TB] FAIL er_rsp_one got %b exp %b", rsp, 2'b00); end
    hrdata = 32'h0;
  endtask

  task automatic test_byte_half();
    logic [3:0]  t_we    [4];
    logic [28:0] t_addr  [4];
    logic [31:0] t_haddr [4];
    logic [2:0]  t_hsize [4];
    t_we[0] = 4'b0100; t_addr[0] = 29'h10; t_haddr[0] = 32'h0000_0012; t_hsize[0] = 3'b000;
    t_we[1] = 4'b1100; t_addr[1] = 29'h10; t_haddr[1] = 32'h0000_0012; t_hsize[1] = 3'b001;
    t_we[2] = 4'b0010; t_addr[2] = 29'h23; t_haddr[2] = 32'h0000_0021; t_hsize[2] = 3'b000;
    t_we[3] = 4'b1000; t_addr[3] = 29'h1000_0040; t_haddr[3] = 32'h1000_0043; t_hsize[3] = 3'b000;
    for (int i = 0; i < 4; i++) begin
      req = 1'b1; we = t_we[i]; addr = t_addr[i]; wdata = 32'hA5A5_0000 | i;
      @(negedge clk);
      checks++; if (htrans !== 2'b10) begin errors++; $display("[TB] FAIL bh_htrans%0d got %b exp %b", i, htrans, 2'b10); end
      checks++; if (haddr !== t_haddr[i]) begin errors++; $display("[TB] FAIL bh_haddr%0d got %h exp %h", i, haddr, t_haddr[i]); end
      checks++; if (hsize !== t_hsize[i]) begin errors++; $display("[TB] FAIL bh_hsize%0d got %b exp %b", i, hsize, t_hsize[i]); end
      checks++; if (hwrite !== 1'b1) begin errors++; $display("[TB] FAIL bh_hwrite%0d got %b exp %b", i, hwrite, 1'b1); end
      @(negedge clk);
      checks++; if (hwdata !== (32'hA5A5_0000 | i)) begin errors++; $display("[TB] FAIL bh_hwdata%0d got %h exp %h", i, hwdata, 32'hA5A5_0000 | i); end
      @(negedge clk);
      checks++; if (rsp !== 2'b01) begin errors++; $display("[TB] FAIL bh_rsp%0d got %b exp %b", i, rsp, 2'b01); end
      req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    req = 1'b1; we = 4'b0101; addr = 29'h0000_0400; wdata = 32'h1;
    @(negedge clk); // N+1
    checks++; if (htrans !== 2'b00) begin errors++; $display("[TB] FAIL il_htrans got %b exp %b", htrans, 2'b00); end
    checks++; if (rsp !== 2'b11) begin errors++; $display("[TB] FAIL il_rsp got %b exp %b", rsp, 2'b11); end
    req = 1'b0; we = 4'b0000;
    @(negedge clk);
    checks++; if (htrans !== 2'b00) begin errors++; $display("[TB] FAIL il_htrans2 got %b exp %b", htrans, 2'b00); end
    checks++; if (rsp !== 2'b00) begin errors++; $display("[TB] FAIL il_rsp_one got %b exp %b", rsp, 2'b00); end
  endtask

  task automatic test_back_to_back();
    req = 1'b1; we = 4'b0000; addr = 29'h0000_0040; hrdata = 32'hAAAA_5555;
    @(negedge clk); // N+1
    checks++; if (htrans !== 2'b10) begin errors++; $display("[TB] FAIL bb_htrans1 got %b exp %b", htrans, 2'b10); end
    @(negedge clk); // N+2
    @(negedge clk); // N+3
    checks++; if (rsp !== 2'b01) begin errors++; $display("[TB] FAIL bb_rsp1 got %b exp %b", rsp, 2'b01); end
    checks++; if (rdata !== 32'hAAAA_5555) begin errors++; $display("[TB] FAIL bb_rdata1 got %h exp %h", rdata, 32'hAAAA_5555); end
    hrdata = 32'h0F0F_F0F0;
    @(negedge clk); // N+4: IDLE samples the still-high req
    checks++; if (htrans !== 2'b00) begin errors++; $display("[TB] FAIL bb_gap_htrans got %b exp %b", htrans, 2'b00); end
    checks++; if (rsp !== 2'b00) begin errors++; $display("[TB] FAIL bb_gap_rsp got %b exp %b", rsp, 2'b00); end
    @(negedge clk); // N+5
    checks++; if (htrans !== 2'b10) begin errors++; $display("[TB] FAIL bb_htrans2 got %b exp %b", htrans, 2'b10); end
    @(negedge clk); // N+6
    @(negedge clk); // N+7
    checks++; if (rsp !== 2'b01) begin errors++; $display("[TB] FAIL bb_rsp2 got %b exp %b", rsp, 2'b01); end
    checks++; if (rdata !== 32'h0F0F_F0F0) begin errors++; $display("[TB] FAIL bb_rdata2 got %h exp %h", rdata, 32'h0F0F_F0F0); end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    req = 1'b1; we = 4'b0000; addr = 29'h0000_0500;
    @(negedge clk); // N+1 address phase
    @(negedge clk); // N+2 data phase, stall
    hready = 1'b0;
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    checks++; if (htrans !== 2'b00) begin errors++; $display("[TB] FAIL rm_htrans got %b exp %b", htrans, 2'b00); end
    checks++; if (rsp !== 2'b00) begin errors++; $display("[TB] FAIL rm_rsp got %b exp %b", rsp, 2'b00); end
    rst = 1'b0; hready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (rsp !== 2'b00 || htrans !== 2'b00) begin errors++; $display("[TB] FAIL rm_quiet%0d got rsp %b htrans %b exp 00 00", i, rsp, htrans); end
    end
    req = 1'b1; we = 4'b0011; addr = 29'h0000_0008; wdata = 32'h0000_BEEF;
    @(negedge clk);
    checks++; if (htrans !== 2'b10) begin errors++; $display("[TB] FAIL rm_new_htrans got %b exp %b", htrans, 2'b10); end
    checks++; if (haddr !== 32'h0000_0008 || hsize !== 3'b001) begin errors++; $display("[TB] FAIL rm_new_ctrl got %h/%b exp %h/%b", haddr, hsize, 32'h8, 3'b001); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp !== 2'b01) begin errors++; $display("[TB] FAIL rm_new_rsp got %b exp %b", rsp, 2'b01); end
    req = 1'b0;
    @(negedge clk);
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_word_write();
    test_read_wait();
    test_error_read();
    test_byte_half();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rcc_ahb_lite_master.md
RCC_AHB_LITE_MASTER -- requirements
Module: rcc_ahb_lite_master

Interface
REQ-001 SHALL have parameter ADDR_HI, default 3'b000, meaning haddr[31:29] driven on every transfer.
REQ-002 SHALL have ports (clock and reset first):
- ahb_hclk  in  1  single clock; all logic on rising edge
- ahb_hreset  in  1  reset, synchronous, active-high
- req  in  1  requester transfer request, held until rsp != 00
- we  in  4  byte write enables; 0000 = word read
- addr  in  29  byte address [28:0]; addr[1:0] ignored, offset derived from we
- wdata  in  32  write data, stable while req high
- rdata  out  32  read data, valid when rsp == 01 for a read
- rsp  out  2  00 none, 01 okay, 11 error; 10 never driven
- ahb_haddr  out  32  AHB address
- ahb_htrans  out  2  IDLE 00 / NONSEQ 10 only
- ahb_hwrite  out  1  write indicator
- ahb_hsize  out  3  000 byte, 001 half, 010 word
- ahb_hburst  out  3  constant 3'b000 (SINGLE)
- ahb_hprot  out  3  constant 3'b011
- ahb_hwdata  out  32  write data, data phase
- ahb_hrdata  in  32  read data
- ahb_hready  in  1  bus ready
- ahb_hresp  in  1  0 OKAY, 1 ERROR

Function
REQ-003 SHALL implement states IDLE, ADDR, DATA, RESP.
REQ-004 IDLE: req=1 with legal we -> latch we/addr/wdata, go ADDR next cycle; req=0 -> stay.
REQ-005 Legal we: 0000 (read, word, offset 00), 1111 (word, 00), 0011 (half, 00), 1100 (half, 10), 0001/0010/0100/1000 (byte, offset 00/01/10/11).
REQ-006 Illegal non-zero we in IDLE SHALL go RESP with rsp=11, no AHB transfer issued.
REQ-007 ahb_haddr = {ADDR_HI, addr[28:2], offset}; hsize per REQ-005; hwrite = (we != 0).
REQ-008 ADDR: htrans=NONSEQ with latched address/control; hold until ahb_hready=1, then go DATA.
REQ-009 DATA: htrans=IDLE; ahb_hwdata = latched wdata for whole phase (unmodified; slave selects lanes); wait while ahb_hready=0.
REQ-010 DATA, ahb_hready=1, ahb_hresp=0 -> capture ahb_hrdata into rdata (reads only), go RESP with okay.
REQ-011 DATA, ahb_hresp=1 -> result error; transfer completes on the second ERROR cycle (hready=1), then RESP with rsp=11; rdata unchanged.
REQ-012 RESP: rsp non-zero for exactly one cycle, then IDLE; a req still high in IDLE the next cycle SHALL start a new transfer.
REQ-013 Latency, zero-wait okay: req sampled cycle N -> NONSEQ cycle N+1 -> data cycle N+2 -> rsp=01 cycle N+3.
REQ-014 Each wait state in ADDR or DATA SHALL add exactly one cycle; no upper bound, no timeout.
REQ-015 Changes on req/we/addr/wdata after IDLE latch SHALL not affect the transfer in flight.
REQ-016 At most one transfer outstanding; no pipelining of address phases; htrans never SEQ/BUSY.
REQ-017 rdata SHALL hold its last captured value until the next okay read.
REQ-018 Control outputs (haddr, hwrite, hsize) SHALL be held stable from ADDR through end of DATA.

Reset
REQ-019 ahb_hreset=1 SHALL, at the next rising edge, force state IDLE, htrans=00, rsp=00, rdata=0, haddr=0, hwrite=0, hsize=010, hwdata=0.
REQ-020 Reset mid-transfer (ADDR or DATA) SHALL abandon it: no rsp ever issued for it, htrans=IDLE from the cycle after reset.
REQ-021 hburst and hprot SHALL be constant including during reset.

Verification
REQ-022 Word write, zero wait: req=1, we=1111, addr=29'h0000_0104, wdata=32'hDEADBEEF -> haddr=32'h0000_0104, hsize=010, hwrite=1, hwdata=DEADBEEF in data cycle, rsp=01 at N+3.
REQ-023 Read with 3 wait states in DATA, hrdata=32'h1234_5678 -> rsp=01 at N+6, rdata=32'h1234_5678 held afterwards.
REQ-024 Byte write we=0100, addr=29'h10 -> haddr=32'h0000_0012, hsize=000; halfword we=1100 -> haddr offset 10, hsize=001.
REQ-025 Slave two-cycle ERROR (hready=0/hresp=1 then hready=1/hresp=1) on read -> rsp=11 one cycle, rdata unchanged.
REQ-026 Illegal we=0101 -> no NONSEQ ever driven, rsp=11 one cycle after request.
REQ-027 ahb_hreset asserted during DATA wait state -> htrans=00, rsp=00 and state IDLE after edge; subsequent request completes normally.
